// File: rtl/wb_stream_writer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stream_writer_sequencer
//  Description : Descriptor scheduler for wb_stream_writer. Buffers descriptors
//                in a small FIFO and, for each one, programs the writer's
//                Wishbone config slave, enables it, waits for its IRQ and
//                clears it.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_stream_writer_sequencer #(
    parameter int WB_AW   = 32,
    parameter int WB_DW   = 32,
    parameter int DESC_AW = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WB_AW-1:0]   desc_adr_i,
    input  logic [WB_DW-1:0]   desc_size_i,
    input  logic [WB_DW-1:0]   desc_burst_i,
    input  logic               desc_valid_i,
    output logic               desc_ready_o,
    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    output logic [WB_DW/8-1:0] wbm_sel_o,
    output logic               wbm_we_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic [2:0]         wbm_cti_o,
    output logic [1:0]         wbm_bte_o,
    input  logic [WB_DW-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    input  logic               wbm_rty_i,
    input  logic               irq_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [15:0]        done_cnt_o
);

    localparam int              c_DEPTH = 2**DESC_AW;
    localparam logic [DESC_AW:0] c_FULL = (DESC_AW+1)'(c_DEPTH);

    localparam logic [WB_AW-1:0] c_ADR_ENABLE = WB_AW'(32'h0);
    localparam logic [WB_AW-1:0] c_ADR_START  = WB_AW'(32'h4);
    localparam logic [WB_AW-1:0] c_ADR_SIZE   = WB_AW'(32'h8);
    localparam logic [WB_AW-1:0] c_ADR_BURST  = WB_AW'(32'hC);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_LOAD     = 3'd1;
    localparam logic [2:0] c_W_ADDR   = 3'd2;
    localparam logic [2:0] c_W_SIZE   = 3'd3;
    localparam logic [2:0] c_W_BURST  = 3'd4;
    localparam logic [2:0] c_W_EN     = 3'd5;
    localparam logic [2:0] c_WAIT_IRQ = 3'd6;
    localparam logic [2:0] c_W_CLR    = 3'd7;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic               r_gap;
    logic               w_wr_state;
    logic               w_access;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;

    logic [WB_AW-1:0]   r_fifo_adr   [c_DEPTH];
    logic [WB_DW-1:0]   r_fifo_size  [c_DEPTH];
    logic [WB_DW-1:0]   r_fifo_burst [c_DEPTH];
    logic [DESC_AW-1:0] r_wr_ptr;
    logic [DESC_AW-1:0] r_rd_ptr;
    logic [DESC_AW:0]   r_count;

    logic [WB_AW-1:0]   r_adr;
    logic [WB_DW-1:0]   r_size;
    logic [WB_DW-1:0]   r_burst;
    logic               r_done;
    logic               r_err;
    logic [15:0]        r_done_cnt;

    // Read data of config writes is meaningless; fold it away explicitly.
    logic               w_unused;
    assign w_unused = ^wbm_dat_i;

    assign w_push       = desc_valid_i && desc_ready_o;
    assign w_pop        = (r_state == c_LOAD);
    assign w_empty      = (r_count == '0);
    assign desc_ready_o = (r_count != c_FULL);

    // A write state drives the bus unless it is serving its mandatory idle gap.
    assign w_wr_state = r_state inside {c_W_ADDR, c_W_SIZE, c_W_BURST, c_W_EN, c_W_CLR};
    assign w_access   = w_wr_state && !r_gap;

    assign wbm_sel_o  = '1;
    assign wbm_cti_o  = 3'b000;
    assign wbm_bte_o  = 2'b00;
    assign busy_o     = (r_state != c_IDLE);
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign done_cnt_o = r_done_cnt;

    // Descriptor storage; contents need no reset since pointers guard them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_adr[r_wr_ptr]   <= desc_adr_i;
            r_fifo_size[r_wr_ptr]  <= desc_size_i;
            r_fifo_burst[r_wr_ptr] <= desc_burst_i;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + DESC_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + DESC_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (DESC_AW+1)'(1);
                2'b01:   r_count <= r_count - (DESC_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Holding registers capture the FIFO head when a descriptor is started.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_adr   <= '0;
            r_size  <= '0;
            r_burst <= '0;
        end else if (w_pop) begin
            r_adr   <= r_fifo_adr[r_rd_ptr];
            r_size  <= r_fifo_size[r_rd_ptr];
            r_burst <= r_fifo_burst[r_rd_ptr];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next;
    end

    // Idle gap after an acked config write that is followed by another, or after a retry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_gap <= 1'b0;
        else     r_gap <= w_access && !wbm_err_i &&
                          (wbm_rty_i ||
                           (wbm_ack_i && (r_state inside {c_W_ADDR, c_W_SIZE, c_W_BURST})));
    end

    // Next-state logic; err beats ack, ack beats rty (rty simply holds the state).
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:     if (!w_empty) w_next = c_LOAD;
            c_LOAD:     w_next = c_W_ADDR;
            c_WAIT_IRQ: if (irq_i) w_next = c_W_CLR;
            default: begin
                if (w_access) begin
                    if (wbm_err_i) begin
                        w_next = c_IDLE;
                    end else if (wbm_ack_i) begin
                        case (r_state)
                            c_W_ADDR:  w_next = c_W_SIZE;
                            c_W_SIZE:  w_next = c_W_BURST;
                            c_W_BURST: w_next = c_W_EN;
                            c_W_EN:    w_next = c_WAIT_IRQ;
                            default:   w_next = c_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // Bus outputs decoded from the current state.
    always_comb begin
        wbm_cyc_o = w_access;
        wbm_stb_o = w_access;
        wbm_we_o  = w_access;
        wbm_adr_o = '0;
        wbm_dat_o = '0;
        case (r_state)
            c_W_ADDR:  begin wbm_adr_o = c_ADR_START;  wbm_dat_o = WB_DW'(r_adr); end
            c_W_SIZE:  begin wbm_adr_o = c_ADR_SIZE;   wbm_dat_o = r_size;        end
            c_W_BURST: begin wbm_adr_o = c_ADR_BURST;  wbm_dat_o = r_burst;       end
            c_W_EN:    begin wbm_adr_o = c_ADR_ENABLE; wbm_dat_o = WB_DW'(1);     end
            c_W_CLR:   begin wbm_adr_o = c_ADR_ENABLE; wbm_dat_o = WB_DW'(2);     end
            default:   ;
        endcase
    end

    // Completion pulse, counter and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_done_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_access && wbm_err_i) r_err <= 1'b1;
            if (w_access && (r_state == c_W_CLR) && wbm_ack_i && !wbm_err_i) begin
                r_done     <= 1'b1;
                r_done_cnt <= r_done_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_stream_writer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_stream_writer_sequencer
//  Description : Self-checking bench: a Wishbone slave model with one-shot
//                rty/err injection and a scoreboard of expected config writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stream_writer_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] desc_adr, desc_size, desc_burst;
    logic        desc_valid, desc_ready;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        s_ack, s_err, s_rty;
    logic        irq;
    logic        busy_o, done_o, err_o;
    logic [15:0] done_cnt_o;

    typedef struct packed { logic [31:0] adr; logic [31:0] dat; } wr_t;
    wr_t sb[$];

    int n_cmp = 0;
    int n_fail = 0;
    int done_seen = 0;
    int total_done = 0;
    int exp_cnt = 0;
    int rty_tok = 0, rty_used = 0, err_tok = 0, err_used = 0;
    logic [31:0] rty_adr = 32'hFFFF_FFFF;
    logic [31:0] err_adr = 32'hFFFF_FFFF;
    bit gap_chk = 0;

    always #5 clk = ~clk;

    wb_stream_writer_sequencer #(.WB_AW(32), .WB_DW(32), .DESC_AW(2)) dut (
        .clk(clk), .rst(rst),
        .desc_adr_i(desc_adr), .desc_size_i(desc_size), .desc_burst_i(desc_burst),
        .desc_valid_i(desc_valid), .desc_ready_o(desc_ready),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(32'h0),
        .wbm_ack_i(s_ack), .wbm_err_i(s_err), .wbm_rty_i(s_rty),
        .irq_i(irq), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .done_cnt_o(done_cnt_o)
    );

    // Zero-wait slave with one-shot rty/err on a chosen address.
    always_comb begin
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        if (wbm_cyc_o && wbm_stb_o) begin
            if (err_tok != err_used && wbm_adr_o == err_adr)      s_err = 1'b1;
            else if (rty_tok != rty_used && wbm_adr_o == rty_adr) s_rty = 1'b1;
            else                                                  s_ack = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (s_err) err_used <= err_used + 1;
        if (s_rty) rty_used <= rty_used + 1;
    end

    // Bus monitor: scoreboard pop on ack, idle gap after every terminating cycle.
    always @(negedge clk) begin
        if (done_o) done_seen++;
        if (rst) begin
            gap_chk = 0;
        end else begin
            if (gap_chk) begin
                n_cmp++;
                if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gap: cyc=%b stb=%b, required 0/0", wbm_cyc_o, wbm_stb_o);
                end
            end
            gap_chk = 0;
            if (wbm_cyc_o && wbm_stb_o) begin
                n_cmp++;
                if (wbm_we_o !== 1'b1 || wbm_sel_o !== 4'hF || wbm_cti_o !== 3'b000 || wbm_bte_o !== 2'b00) begin
                    n_fail++;
                    $display("FAIL bus_ctl: we=%b sel=%h cti=%b bte=%b, required 1/f/000/00",
                             wbm_we_o, wbm_sel_o, wbm_cti_o, wbm_bte_o);
                end
                if (s_ack) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_write: adr=%h dat=%h, required none", wbm_adr_o, wbm_dat_o);
                    end else begin
                        wr_t e;
                        e = sb.pop_front();
                        if (wbm_adr_o !== e.adr || wbm_dat_o !== e.dat) begin
                            n_fail++;
                            $display("FAIL write: adr=%h dat=%h, required adr=%h dat=%h",
                                     wbm_adr_o, wbm_dat_o, e.adr, e.dat);
                        end
                    end
                end
                if (s_ack || s_err || s_rty) gap_chk = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_desc(input logic [31:0] a, input logic [31:0] s,
                             input logic [31:0] b, input bit full_seq);
        int t = 0;
        while (!desc_ready && t < 200) begin tick(); t++; end
        n_cmp++;
        if (!desc_ready) begin
            n_fail++;
            $display("FAIL push_timeout: ready=%b, required 1", desc_ready);
        end
        desc_adr = a; desc_size = s; desc_burst = b; desc_valid = 1'b1;
        tick();
        desc_valid = 1'b0;
        if (full_seq) begin
            sb.push_back('{32'h4, a});
            sb.push_back('{32'h8, s});
            sb.push_back('{32'hC, b});
            sb.push_back('{32'h0, 32'h1});
            sb.push_back('{32'h0, 32'h2});
        end
    endtask

    task automatic pulse_irq();
        irq = 1'b1; tick(); irq = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        bit ok = 0;
        while (t < 40 && !ok) begin tick(); t++; if (done_o) ok = 1; end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_done_timeout: done_o not seen in 40 cycles, required pulse", name);
        end else begin
            exp_cnt++; total_done++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; desc_valid = 1'b0; irq = 1'b0;
        desc_adr = '0; desc_size = '0; desc_burst = '0;
        repeat (3) tick();
        n_cmp++;
        if (desc_ready !== 1'b1 || wbm_sel_o !== 4'hF || wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 ||
            busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 || done_cnt_o !== 16'd0 ||
            wbm_adr_o !== 32'd0 || wbm_dat_o !== 32'd0 || wbm_we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b sel=%h cyc=%b busy=%b done=%b err=%b cnt=%0d, required 1 f 0 0 0 0 0",
                     desc_ready, wbm_sel_o, wbm_cyc_o, busy_o, done_o, err_o, done_cnt_o);
        end
        @(negedge clk); rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int lat;
        push_desc(32'h40, 32'd32, 32'd8, 1);
        lat = 1;
        while (!wbm_stb_o && lat < 10) begin tick(); lat++; end
        n_cmp++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL first_stb_latency: %0d cycles, required 3", lat);
        end
        repeat (12) tick();
        n_cmp++;
        if (sb.size() != 1 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_irq: pending=%0d busy=%b, required 1 and 1", sb.size(), busy_o);
        end
        pulse_irq();
        wait_done("single");
        n_cmp++;
        if (done_cnt_o !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL single_cnt: %0d, required %0d", done_cnt_o, exp_cnt);
        end
        repeat (3) tick();
        n_cmp++;
        if (done_seen != total_done || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse: done cycles=%0d busy=%b, required %0d and 0", done_seen, busy_o, total_done);
        end
    endtask

    task automatic test_fill();
        int k;
        for (int i = 0; i < 5; i++)
            push_desc(32'h1000 + 32'(i) * 32'h100, (i == 2) ? 32'd0 : 32'd16 * 32'(i + 1),
                      (i == 2) ? 32'd0 : 32'd4, 1);
        n_cmp++;
        if (desc_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready: %b, required 0", desc_ready);
        end
        for (int i = 0; i < 5; i++) begin
            repeat (16) tick();
            pulse_irq();
            wait_done("fill");
            if (i < 4) begin
                k = 0;
                while (!wbm_stb_o && k < 10) begin tick(); k++; end
                n_cmp++;
                if (k != 2) begin
                    n_fail++;
                    $display("FAIL back_to_back: %0d cycles done->stb, required 2", k);
                end
                if (i == 0) begin
                    n_cmp++;
                    if (desc_ready !== 1'b1) begin
                        n_fail++;
                        $display("FAIL ready_after_pop: %b, required 1", desc_ready);
                    end
                end
            end
        end
        n_cmp++;
        if (done_cnt_o !== 16'(exp_cnt) || sb.size() != 0) begin
            n_fail++;
            $display("FAIL fill_cnt: cnt=%0d pending=%0d, required %0d and 0", done_cnt_o, sb.size(), exp_cnt);
        end
    endtask

    task automatic test_retry();
        rty_adr = 32'h8; rty_tok++;
        push_desc(32'h2000, 32'd64, 32'd8, 1);
        repeat (20) tick();
        n_cmp++;
        if (rty_used != rty_tok || sb.size() != 1) begin
            n_fail++;
            $display("FAIL retry_seq: rty_used=%0d pending=%0d, required %0d and 1", rty_used, sb.size(), rty_tok);
        end
        pulse_irq();
        wait_done("retry");
        n_cmp++;
        if (done_cnt_o !== 16'(exp_cnt) || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL retry_cnt: cnt=%0d err=%b, required %0d and 0", done_cnt_o, err_o, exp_cnt);
        end
    endtask

    task automatic test_err();
        err_adr = 32'hC; err_tok++;
        push_desc(32'h3000, 32'd24, 32'd2, 0);
        sb.push_back('{32'h4, 32'h3000});
        sb.push_back('{32'h8, 32'd24});
        push_desc(32'h3400, 32'd48, 32'd3, 1);
        repeat (30) tick();
        n_cmp++;
        if (err_o !== 1'b1 || err_used != err_tok || done_cnt_o !== 16'(exp_cnt) || sb.size() != 1) begin
            n_fail++;
            $display("FAIL err_abandon: err=%b cnt=%0d pending=%0d, required 1 %0d 1", err_o, done_cnt_o, sb.size(), exp_cnt);
        end
        pulse_irq();
        wait_done("err_next");
        repeat (2) tick();
        n_cmp++;
        if (err_o !== 1'b1 || done_cnt_o !== 16'(exp_cnt) || sb.size() != 0) begin
            n_fail++;
            $display("FAIL err_sticky: err=%b cnt=%0d pending=%0d, required 1 %0d 0", err_o, done_cnt_o, sb.size(), exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        push_desc(32'h5000, 32'd32, 32'd4, 0);
        sb.push_back('{32'h4, 32'h5000});
        sb.push_back('{32'h8, 32'd32});
        sb.push_back('{32'hC, 32'd4});
        sb.push_back('{32'h0, 32'h1});
        push_desc(32'h5100, 32'd32, 32'd4, 0);
        push_desc(32'h5200, 32'd32, 32'd4, 0);
        repeat (20) tick();
        n_cmp++;
        if (sb.size() != 0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: pending=%0d busy=%b, required 0 and 1", sb.size(), busy_o);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (wbm_cyc_o !== 1'b0 || busy_o !== 1'b0 || desc_ready !== 1'b1 ||
            done_cnt_o !== 16'd0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: cyc=%b busy=%b rdy=%b cnt=%0d err=%b, required 0 0 1 0 0",
                     wbm_cyc_o, busy_o, desc_ready, done_cnt_o, err_o);
        end
        exp_cnt = 0;
        repeat (2) tick();
        @(negedge clk); rst = 1'b0;
        repeat (20) tick();
        pulse_irq();
        repeat (20) tick();
        n_cmp++;
        if (busy_o !== 1'b0 || done_cnt_o !== 16'd0 || desc_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset: busy=%b cnt=%0d rdy=%b, required 0 0 1", busy_o, done_cnt_o, desc_ready);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, s, b;
        int m;
        for (int i = 0; i < 20; i++) begin
            a = $urandom & 32'hFFFF_FFFC;
            b = 32'($urandom_range(2, 8));
            m = $urandom_range(1, 128 / (int'(b) * 4));
            s = 32'(m) * b * 32'd4;
            push_desc(a, s, b, 1);
            repeat (14) tick();
            pulse_irq();
            wait_done("random");
        end
        repeat (3) tick();
        n_cmp++;
        if (done_cnt_o !== 16'(exp_cnt) || sb.size() != 0 || done_seen != total_done) begin
            n_fail++;
            $display("FAIL random_cnt: cnt=%0d pending=%0d pulses=%0d, required %0d 0 %0d",
                     done_cnt_o, sb.size(), done_seen, exp_cnt, total_done);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_retry();
        test_err();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
